// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory access controller: FSM encodings,
// requester ids and default widths.
package dmem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  localparam logic REQ_CPU = 1'b0;
  localparam logic REQ_DMA = 1'b1;

  localparam int DEF_DATA_W  = 64;
  localparam int DEF_ADDR_W  = 64;
  localparam int DEF_MEMSIZE = 64;

endpackage

// File: rtl/dmem_rr_arb.sv
// Two-input round-robin arbiter: a lone requester wins; on a tie the one
// that did not win last time is chosen. Output is one-hot (or zero).
module dmem_rr_arb
  import dmem_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = (last == REQ_DMA) ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/dmem_access_ctrl.sv
// Shares a single-port data memory between the CPU (port 0) and the loader/DMA
// (port 1): round-robin arbitration, range check, one access in flight.
module dmem_access_ctrl
  import dmem_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int MEMSIZE = DEF_MEMSIZE
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              r0_req,
  input  logic              r0_we,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [DATA_W-1:0] r0_wdata,
  output logic              r0_gnt,
  output logic              r0_ack,
  output logic              r0_err,
  output logic [DATA_W-1:0] r0_rdata,
  input  logic              r1_req,
  input  logic              r1_we,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [DATA_W-1:0] r1_wdata,
  output logic              r1_gnt,
  output logic              r1_ack,
  output logic              r1_err,
  output logic [DATA_W-1:0] r1_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam logic [ADDR_W-1:0] ADDR_LIMIT = ADDR_W'(MEMSIZE);

  state_t            state;
  logic              win;
  logic              last;
  logic              cmd_we;
  logic              cmd_err;
  logic [DATA_W-1:0] rdata0;
  logic [DATA_W-1:0] rdata1;
  logic [1:0]        grant;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  dmem_rr_arb u_arb (
    .req   ({r1_req, r0_req}),
    .last  (last),
    .grant (grant)
  );

  always_comb begin
    sel_we    = grant[1] ? r1_we    : r0_we;
    sel_addr  = grant[1] ? r1_addr  : r0_addr;
    sel_wdata = grant[1] ? r1_wdata : r0_wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      win       <= REQ_CPU;
      last      <= REQ_DMA;
      cmd_we    <= 1'b0;
      cmd_err   <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rdata0    <= '0;
      rdata1    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (|grant) begin
            win       <= grant[1];
            last      <= grant[1];
            cmd_we    <= sel_we;
            cmd_err   <= !(sel_addr < ADDR_LIMIT);
            mem_addr  <= sel_addr;
            mem_wdata <= sel_wdata;
            state     <= ST_ISSUE;
          end
        end
        ST_ISSUE: state <= ST_CAPTURE;
        ST_CAPTURE: begin
          // memory read data is valid now, one cycle after mem_re
          if (!cmd_we && !cmd_err) begin
            if (win == REQ_DMA) rdata1 <= mem_rdata;
            else                rdata0 <= mem_rdata;
          end
          state <= ST_DONE;
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    busy     = (state != ST_IDLE);
    mem_we   = !rst && (state == ST_ISSUE) && !cmd_err &&  cmd_we;
    mem_re   = !rst && (state == ST_ISSUE) && !cmd_err && !cmd_we;
    r0_gnt   = (state == ST_ISSUE) && (win == REQ_CPU);
    r1_gnt   = (state == ST_ISSUE) && (win == REQ_DMA);
    r0_ack   = (state == ST_DONE)  && (win == REQ_CPU);
    r1_ack   = (state == ST_DONE)  && (win == REQ_DMA);
    r0_err   = r0_ack && cmd_err;
    r1_err   = r1_ack && cmd_err;
    r0_rdata = rdata0;
    r1_rdata = rdata1;
  end

endmodule
